// File: rtl/wb_queue_pkg.sv
// rtl/wb_queue_pkg.sv - writeback select, load size encodings and default widths
package wb_queue_pkg;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_SIMD_DATA_WIDTH = 128;
  localparam int DEF_DEPTH           = 4;
  localparam int DEF_REG_ADDR_WIDTH  = 5;

endpackage

// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - MEM/WB entry, memory response and register-file write bundle
interface wb_queue_if
  import wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SIMD_DATA_WIDTH = DEF_SIMD_DATA_WIDTH,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int REG_ADDR_WIDTH  = DEF_REG_ADDR_WIDTH
);

  logic                       in_valid;
  logic                       in_ready;
  logic                       in_wb_sel;
  logic [SIMD_DATA_WIDTH-1:0] in_alu_data;
  logic [REG_ADDR_WIDTH-1:0]  in_rd_addr;
  logic                       in_reg_wrt;
  logic [1:0]                 in_ld_size;
  logic                       in_ld_unsigned;
  logic [1:0]                 in_byte_off;
  logic                       mem_rsp_valid;
  logic [DATA_WIDTH-1:0]      mem_rsp_data;
  logic                       flush;
  logic                       wb_valid;
  logic [REG_ADDR_WIDTH-1:0]  wb_addr;
  logic [SIMD_DATA_WIDTH-1:0] wb_data;
  logic [$clog2(DEPTH):0]     pending_cnt;
  logic                       rsp_err;

  modport master (
    output in_valid, in_wb_sel, in_alu_data, in_rd_addr, in_reg_wrt,
           in_ld_size, in_ld_unsigned, in_byte_off,
           mem_rsp_valid, mem_rsp_data, flush,
    input  in_ready, wb_valid, wb_addr, wb_data, pending_cnt, rsp_err
  );

  modport slave (
    input  in_valid, in_wb_sel, in_alu_data, in_rd_addr, in_reg_wrt,
           in_ld_size, in_ld_unsigned, in_byte_off,
           mem_rsp_valid, mem_rsp_data, flush,
    output in_ready, wb_valid, wb_addr, wb_data, pending_cnt, rsp_err
  );

endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - shifts a load response to bit 0 and sign/zero extends it
module wb_load_align
  import wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SIMD_DATA_WIDTH = DEF_SIMD_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]      data,
  input  logic [1:0]                 byte_off,
  input  logic [1:0]                 ld_size,
  input  logic                       ld_unsigned,
  output logic [SIMD_DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;

  always_comb begin
    shifted = data >> {byte_off, 3'b000};
    case (ld_size)
      LD_B:    ext = {{(DATA_WIDTH-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
      LD_H:    ext = {{(DATA_WIDTH-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;  // reserved 2'b11 behaves as a word load
    endcase
    result = SIMD_DATA_WIDTH'(ext);
  end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback queue holding ALU results and pending loads
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SIMD_DATA_WIDTH = DEF_SIMD_DATA_WIDTH,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int REG_ADDR_WIDTH  = DEF_REG_ADDR_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  wb_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [REG_ADDR_WIDTH-1:0]  e_rd    [DEPTH];
  logic                       e_wrt   [DEPTH];
  logic [SIMD_DATA_WIDTH-1:0] e_data  [DEPTH];
  logic [1:0]                 e_size  [DEPTH];
  logic                       e_uns   [DEPTH];
  logic [1:0]                 e_off   [DEPTH];
  logic [DEPTH-1:0]           e_rdy;

  logic [PW-1:0] rd_ptr, wr_ptr, count;
  logic [AW-1:0] head, tail, scan_idx, rsp_idx;
  logic          rsp_hit, head_ok, accept, retire, rsp_fill;
  logic [SIMD_DATA_WIDTH-1:0] load_result;

  assign count           = wr_ptr - rd_ptr;
  assign head            = rd_ptr[AW-1:0];
  assign tail            = wr_ptr[AW-1:0];
  assign bus.pending_cnt = count;
  assign bus.in_ready    = rst_n && (count < PW'(DEPTH));

  // Oldest occupied entry still waiting for load data, searched from the head.
  always_comb begin
    rsp_hit  = 1'b0;
    rsp_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + AW'(i);
      if (!rsp_hit && (PW'(i) < count) && !e_rdy[scan_idx]) begin
        rsp_hit = 1'b1;
        rsp_idx = scan_idx;
      end
    end
  end

  assign head_ok  = (count != '0) && e_rdy[head];
  assign accept   = bus.in_valid && bus.in_ready && !bus.flush;
  assign retire   = head_ok && !bus.flush;
  assign rsp_fill = bus.mem_rsp_valid && rsp_hit && !bus.flush;

  wb_load_align #(
    .DATA_WIDTH     (DATA_WIDTH),
    .SIMD_DATA_WIDTH(SIMD_DATA_WIDTH)
  ) u_align (
    .data       (bus.mem_rsp_data),
    .byte_off   (e_off[rsp_idx]),
    .ld_size    (e_size[rsp_idx]),
    .ld_unsigned(e_uns[rsp_idx]),
    .result     (load_result)
  );

  // Entry payload needs no reset: occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      e_rd[tail]   <= bus.in_rd_addr;
      e_wrt[tail]  <= bus.in_reg_wrt;
      e_data[tail] <= bus.in_alu_data;
      e_size[tail] <= bus.in_ld_size;
      e_uns[tail]  <= bus.in_ld_unsigned;
      e_off[tail]  <= bus.in_byte_off;
      e_rdy[tail]  <= (bus.in_wb_sel == WB_ALU);
    end
    if (rsp_fill) begin
      e_data[rsp_idx] <= load_result;
      e_rdy[rsp_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_addr  <= '0;
      bus.wb_data  <= '0;
      bus.rsp_err  <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      bus.wb_valid <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (retire) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        bus.wb_valid <= e_wrt[head] && (e_rd[head] != '0);
        bus.wb_addr  <= e_rd[head];
        bus.wb_data  <= e_data[head];
      end else begin
        bus.wb_valid <= 1'b0;
      end
      if (bus.mem_rsp_valid && !rsp_hit)
        bus.rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed self-checking bench for wb_queue
module tb_wb_queue;
  import wb_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_queue_if q ();

  wb_queue dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic sel, input logic [4:0] rd, input logic wrt,
                      input logic [127:0] alu, input logic [1:0] sz,
                      input logic uns, input logic [1:0] off);
    q.in_valid       = 1'b1;
    q.in_wb_sel      = sel;
    q.in_rd_addr     = rd;
    q.in_reg_wrt     = wrt;
    q.in_alu_data    = alu;
    q.in_ld_size     = sz;
    q.in_ld_unsigned = uns;
    q.in_byte_off    = off;
    tick();
    q.in_valid = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d);
    q.mem_rsp_valid = 1'b1;
    q.mem_rsp_data  = d;
    tick();
    q.mem_rsp_valid = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input logic [4:0] a, input logic [127:0] d);
    chk({tag, "_valid"}, 128'(q.wb_valid), 128'd1);
    chk({tag, "_addr"}, 128'(q.wb_addr), 128'(a));
    chk({tag, "_data"}, q.wb_data, d);
  endtask

  initial begin
    rst_n = 1'b0;
    q.in_valid = 0; q.in_wb_sel = 0; q.in_alu_data = '0; q.in_rd_addr = '0;
    q.in_reg_wrt = 0; q.in_ld_size = 0; q.in_ld_unsigned = 0; q.in_byte_off = 0;
    q.mem_rsp_valid = 0; q.mem_rsp_data = '0; q.flush = 0;
    tick();
    tick();
    chk("rst_in_ready", 128'(q.in_ready), 128'd0);
    chk("rst_wb_valid", 128'(q.wb_valid), 128'd0);
    chk("rst_wb_addr", 128'(q.wb_addr), 128'd0);
    chk("rst_wb_data", q.wb_data, 128'd0);
    chk("rst_pending", 128'(q.pending_cnt), 128'd0);
    chk("rst_rsp_err", 128'(q.rsp_err), 128'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(q.in_ready), 128'd1);

    // ALU entry on an empty queue
    push(WB_ALU, 5'd3, 1'b1, 128'h1234, LD_W, 1'b0, 2'd0);
    chk("alu_pending", 128'(q.pending_cnt), 128'd1);
    chk("alu_no_wb_yet", 128'(q.wb_valid), 128'd0);
    tick();
    expect_wb("alu", 5'd3, 128'h1234);
    chk("alu_drained", 128'(q.pending_cnt), 128'd0);
    tick();
    chk("alu_wb_drop", 128'(q.wb_valid), 128'd0);

    // Signed byte load, offset 2
    push(WB_MEM, 5'd5, 1'b1, 128'hDEAD, LD_B, 1'b0, 2'd2);
    rsp(32'h00F30000);
    chk("lb_fill_no_wb", 128'(q.wb_valid), 128'd0);
    chk("lb_fill_pending", 128'(q.pending_cnt), 128'd1);
    tick();
    expect_wb("lb", 5'd5, 128'hFFFFFFF3);
    // Unsigned byte load, offset 2
    push(WB_MEM, 5'd6, 1'b1, 128'h0, LD_B, 1'b1, 2'd0 + 2'd2);
    rsp(32'h00F30000);
    tick();
    expect_wb("lbu", 5'd6, 128'hF3);
    // Signed halfword at offset 2 and a full word
    push(WB_MEM, 5'd7, 1'b1, 128'h0, LD_H, 1'b0, 2'd2);
    rsp(32'h8001ABCD);
    tick();
    expect_wb("lh", 5'd7, 128'hFFFF8001);
    push(WB_MEM, 5'd8, 1'b1, 128'h0, 2'b11, 1'b0, 2'd0);
    rsp(32'hDEADBEEF);
    tick();
    expect_wb("lw_rsv", 5'd8, 128'hDEADBEEF);
    tick();

    // Blocked load at the head, then in-order drain
    push(WB_MEM, 5'd7, 1'b1, 128'h0, LD_W, 1'b0, 2'd0);
    push(WB_ALU, 5'd8, 1'b1, 128'hA, LD_W, 1'b0, 2'd0);
    push(WB_ALU, 5'd9, 1'b1, 128'hB, LD_W, 1'b0, 2'd0);
    chk("blk_pending", 128'(q.pending_cnt), 128'd3);
    for (int i = 0; i < 5; i++) begin
      chk("blk_no_wb", 128'(q.wb_valid), 128'd0);
      tick();
    end
    rsp(32'h11223344);
    chk("blk_fill_no_wb", 128'(q.wb_valid), 128'd0);
    tick();
    expect_wb("blk0", 5'd7, 128'h11223344);
    tick();
    expect_wb("blk1", 5'd8, 128'hA);
    tick();
    expect_wb("blk2", 5'd9, 128'hB);
    tick();
    chk("blk_done_valid", 128'(q.wb_valid), 128'd0);
    chk("blk_done_pending", 128'(q.pending_cnt), 128'd0);

    // Accept and retire at the same edge
    push(WB_ALU, 5'd1, 1'b1, 128'h1, LD_W, 1'b0, 2'd0);
    push(WB_ALU, 5'd2, 1'b1, 128'h2, LD_W, 1'b0, 2'd0);
    chk("sim_pending", 128'(q.pending_cnt), 128'd1);
    expect_wb("sim0", 5'd1, 128'h1);
    tick();
    expect_wb("sim1", 5'd2, 128'h2);
    tick();

    // Full queue with a waiting load at the head
    push(WB_MEM, 5'd10, 1'b1, 128'h0, LD_W, 1'b0, 2'd0);
    push(WB_ALU, 5'd11, 1'b1, 128'h11, LD_W, 1'b0, 2'd0);
    push(WB_ALU, 5'd12, 1'b1, 128'h12, LD_W, 1'b0, 2'd0);
    push(WB_ALU, 5'd13, 1'b1, 128'h13, LD_W, 1'b0, 2'd0);
    chk("full_pending", 128'(q.pending_cnt), 128'd4);
    chk("full_in_ready", 128'(q.in_ready), 128'd0);
    push(WB_ALU, 5'd20, 1'b1, 128'h20, LD_W, 1'b0, 2'd0);
    chk("full_reject", 128'(q.pending_cnt), 128'd4);
    rsp(32'h55);
    chk("full_edge1_ready", 128'(q.in_ready), 128'd0);
    tick();
    chk("full_edge2_ready", 128'(q.in_ready), 128'd1);
    chk("full_edge2_pending", 128'(q.pending_cnt), 128'd3);
    expect_wb("full0", 5'd10, 128'h55);
    tick();
    expect_wb("full1", 5'd11, 128'h11);
    tick();
    expect_wb("full2", 5'd12, 128'h12);
    tick();
    expect_wb("full3", 5'd13, 128'h13);
    tick();
    chk("full_empty", 128'(q.pending_cnt), 128'd0);

    // Flush with outstanding entries and a same-cycle response
    push(WB_MEM, 5'd14, 1'b1, 128'h0, LD_W, 1'b0, 2'd0);
    push(WB_ALU, 5'd15, 1'b1, 128'h15, LD_W, 1'b0, 2'd0);
    push(WB_MEM, 5'd16, 1'b1, 128'h0, LD_W, 1'b0, 2'd0);
    chk("fl_pending_before", 128'(q.pending_cnt), 128'd3);
    q.flush = 1'b1;
    rsp(32'h77);
    q.flush = 1'b0;
    chk("fl_pending", 128'(q.pending_cnt), 128'd0);
    chk("fl_wb_valid", 128'(q.wb_valid), 128'd0);
    chk("fl_rsp_err", 128'(q.rsp_err), 128'd0);
    tick();
    chk("fl_no_wb_later", 128'(q.wb_valid), 128'd0);

    // x0 and non-writing entries retire silently
    push(WB_ALU, 5'd0, 1'b1, 128'h99, LD_W, 1'b0, 2'd0);
    tick();
    chk("x0_silent", 128'(q.wb_valid), 128'd0);
    chk("x0_retired", 128'(q.pending_cnt), 128'd0);
    push(WB_ALU, 5'd4, 1'b0, 128'h44, LD_W, 1'b0, 2'd0);
    tick();
    chk("nowrt_silent", 128'(q.wb_valid), 128'd0);
    chk("nowrt_retired", 128'(q.pending_cnt), 128'd0);

    // Unmatched response is sticky through flush until reset
    chk("err_before", 128'(q.rsp_err), 128'd0);
    rsp(32'h1);
    chk("err_set", 128'(q.rsp_err), 128'd1);
    q.flush = 1'b1;
    tick();
    q.flush = 1'b0;
    tick();
    chk("err_sticky", 128'(q.rsp_err), 128'd1);
    rst_n = 1'b0;
    tick();
    chk("err_rst_in_ready", 128'(q.in_ready), 128'd0);
    chk("err_cleared", 128'(q.rsp_err), 128'd0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
